// File: rtl/stream_demux.sv
// stream_demux: 1-to-NUM_OUT demultiplexer for valid/ready streams.
// Each output port owns one holding register, so an accepted beat appears
// on its port one cycle after acceptance and a stalled port only blocks
// beats addressed to it. Beats carrying an out-of-range select are
// accepted, dropped and flagged on err_o for one cycle.
// Optional build macro STREAM_DEMUX_CNT_EN adds cnt_o: one saturating
// 16-bit drain counter per output port.
module stream_demux #(
    parameter int NUM_OUT = 2,
    parameter int DATA_W  = 8,
    localparam int SEL_W  = $clog2(NUM_OUT)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [SEL_W-1:0]            sel_i,
    input  logic [DATA_W-1:0]           in_data_i,
    output logic [NUM_OUT-1:0]          out_valid_o,
    input  logic [NUM_OUT-1:0]          out_ready_i,
    output logic [NUM_OUT*DATA_W-1:0]   out_data_o,
    output logic                        err_o
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [NUM_OUT*16-1:0]       cnt_o
`endif
);

    // NUM_OUT widened by one bit so it can be compared against any select
    // value, including the case where NUM_OUT is an exact power of two.
    localparam logic [SEL_W:0] NUM_OUT_W = (SEL_W+1)'(NUM_OUT);

    logic                      sel_legal;
    logic [NUM_OUT-1:0]        sel_hit;
    logic                      in_ready;
    logic                      accept;
    logic [NUM_OUT-1:0]        load;
    logic [NUM_OUT-1:0]        drain;

    logic [NUM_OUT-1:0]        vld_q;
    logic [NUM_OUT-1:0]        vld_d;
    logic [NUM_OUT*DATA_W-1:0] dat_q;
    logic [NUM_OUT*DATA_W-1:0] dat_d;
    logic                      err_q;
    logic                      err_d;

    // Decode the select and work out acceptance, loads and drains.
    always_comb begin
        sel_legal = ({1'b0, sel_i} < NUM_OUT_W);
        sel_hit   = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            sel_hit[k] = sel_legal && (sel_i == SEL_W'(k));
        end
        // An illegal select never waits: the beat is swallowed at once.
        // A legal select only waits on its own port being full and stalled.
        in_ready = !rst_i && (!sel_legal || |(sel_hit & (~vld_q | out_ready_i)));
        accept   = in_valid_i && in_ready;
        load     = sel_hit & {NUM_OUT{accept}};
        drain    = vld_q & out_ready_i;
    end

    // Next state of the per-port holding registers; a load overrides a drain.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (load[k]) begin
                vld_d[k]                   = 1'b1;
                dat_d[k*DATA_W +: DATA_W]  = in_data_i;
            end else if (drain[k]) begin
                vld_d[k] = 1'b0;
            end
        end
        err_d = accept && !sel_legal;
    end

    // Holding registers and error pulse; reset empties every port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            dat_q <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            err_q <= err_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = vld_q;
    assign out_data_o  = dat_q;
    assign err_o       = err_q;

`ifdef STREAM_DEMUX_CNT_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NUM_OUT*16-1:0] cnt_q;
    logic [NUM_OUT*16-1:0] cnt_d;

    // Count one per drain on each port.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (drain[k]) begin
                cnt_d[k*16 +: 16] = sat_inc16(cnt_q[k*16 +: 16]);
            end
        end
    end

    // Counter registers; reset wins over a simultaneous drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: directed scenarios plus randomized traffic
// checked against a per-port FIFO model of accepted-but-undelivered beats.
module tb_stream_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Two-port instance
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  sel;
    logic [7:0]  in_data;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [15:0] out_data;
    logic        err;
`ifdef STREAM_DEMUX_CNT_EN
    logic [31:0] cnt;
`endif

    // Three-port instance (has an illegal select value)
    logic        in_valid3;
    logic        in_ready3;
    logic [1:0]  sel3;
    logic [7:0]  in_data3;
    logic [2:0]  out_valid3;
    logic [2:0]  out_ready3;
    logic [23:0] out_data3;
    logic        err3;
`ifdef STREAM_DEMUX_CNT_EN
    logic [47:0] cnt3;
`endif

    stream_demux #(.NUM_OUT(2), .DATA_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .sel_i(sel), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .err_o(err)
`ifdef STREAM_DEMUX_CNT_EN
        , .cnt_o(cnt)
`endif
    );

    stream_demux #(.NUM_OUT(3), .DATA_W(8)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid3), .in_ready_o(in_ready3),
        .sel_i(sel3), .in_data_i(in_data3),
        .out_valid_o(out_valid3), .out_ready_i(out_ready3),
        .out_data_o(out_data3), .err_o(err3)
`ifdef STREAM_DEMUX_CNT_EN
        , .cnt_o(cnt3)
`endif
    );

    // Reference model for the two-port instance: per-port FIFO of beats that
    // were accepted and not yet taken by the consumer, plus drain counts.
    logic [7:0] mbuf [2][16];
    int         mhead [2];
    int         mcnt  [2];
    int         mcount[2];

    function automatic bit m_ready();
        return !rst && (mcnt[sel] == 0 || out_ready[sel]);
    endfunction

    task automatic set_in(input bit v, input bit s, input logic [7:0] d, input logic [1:0] r);
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // Advance the model by one clock using the inputs currently applied,
    // then advance the DUTs and sample point.
    task automatic tick();
        bit acc;
        bit drn [2];
        int s;
        acc = in_valid && m_ready();
        s   = sel;
        for (int k = 0; k < 2; k++) drn[k] = (mcnt[k] != 0) && out_ready[k];
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mcnt[k] = 0; mhead[k] = 0; mcount[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (drn[k]) begin
                    mhead[k] = (mhead[k] + 1) % 16;
                    mcnt[k]  = mcnt[k] - 1;
                    if (mcount[k] < 65535) mcount[k] = mcount[k] + 1;
                end
            end
            if (acc) begin
                mbuf[s][(mhead[s] + mcnt[s]) % 16] = in_data;
                mcnt[s] = mcnt[s] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 1'b0, 8'h77, 2'b00);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_pre: got %b want 0", in_ready); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
            checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", out_valid); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
            checks++; if (out_valid3 !== 3'b000 || err3 !== 1'b0 || in_ready3 !== 1'b0) begin
                errors++; $display("FAIL reset_dut3: valid %b err %b ready %b want 000 0 0", out_valid3, err3, in_ready3);
            end
        end
        rst = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 2'b00);
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL post_reset_valid: got %b want 00", out_valid); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
            tick();
        end
    endtask

    task automatic test_routing();
        set_in(1'b1, 1'b0, 8'hA5, 2'b11);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready0: got %b want 1", in_ready); end
        tick();
        set_in(1'b1, 1'b1, 8'h3C, 2'b11);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL route_ready1: got %b want 1", in_ready); end
        checks++; if (out_valid !== 2'b01 || out_data[7:0] !== 8'hA5) begin
            errors++; $display("FAIL route_port0: valid %b data %h want 01 a5", out_valid, out_data[7:0]);
        end
        tick();
        set_in(1'b0, 1'b0, 8'h00, 2'b11);
        checks++; if (out_valid !== 2'b10 || out_data[15:8] !== 8'h3C) begin
            errors++; $display("FAIL route_port1: valid %b data %h want 10 3c", out_valid, out_data[15:8]);
        end
        tick();
    endtask

    task automatic test_stall_isolation();
        set_in(1'b1, 1'b0, 8'h11, 2'b10);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_first_ready: got %b want 1", in_ready); end
        tick();
        set_in(1'b1, 1'b0, 8'h22, 2'b10);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_blocked: got %b want 0", in_ready); end
        checks++; if (out_valid !== 2'b01 || out_data[7:0] !== 8'h11) begin
            errors++; $display("FAIL stall_hold: valid %b data %h want 01 11", out_valid, out_data[7:0]);
        end
        tick();
        set_in(1'b1, 1'b1, 8'h33, 2'b10);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_other_port: got %b want 1", in_ready); end
        checks++; if (out_data[7:0] !== 8'h11) begin errors++; $display("FAIL stall_stable: got %h want 11", out_data[7:0]); end
        tick();
        set_in(1'b1, 1'b0, 8'h22, 2'b10);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_still_blocked: got %b want 0", in_ready); end
        checks++; if (out_valid !== 2'b11 || out_data[15:8] !== 8'h33) begin
            errors++; $display("FAIL stall_port1: valid %b data %h want 11 33", out_valid, out_data[15:8]);
        end
        tick();
        set_in(1'b1, 1'b0, 8'h22, 2'b11);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", in_ready); end
        checks++; if (out_valid !== 2'b01 || out_data[7:0] !== 8'h11) begin
            errors++; $display("FAIL stall_drain: valid %b data %h want 01 11", out_valid, out_data[7:0]);
        end
        tick();
        set_in(1'b0, 1'b0, 8'h00, 2'b11);
        checks++; if (out_valid !== 2'b01 || out_data[7:0] !== 8'h22) begin
            errors++; $display("FAIL stall_second: valid %b data %h want 01 22", out_valid, out_data[7:0]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, 1'b0, 8'(i + 1), 2'b01);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            if (i > 0) begin
                checks++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'(i)) begin
                    errors++; $display("FAIL b2b_data[%0d]: valid %b data %h want 1 %h", i, out_valid[0], out_data[7:0], 8'(i));
                end
            end
            tick();
        end
        set_in(1'b0, 1'b0, 8'h00, 2'b01);
        checks++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h10) begin
            errors++; $display("FAIL b2b_last: valid %b data %h want 1 10", out_valid[0], out_data[7:0]);
        end
        tick();
        checks++; if (out_valid !== 2'b00) begin errors++; $display("FAIL b2b_empty: got %b want 00", out_valid); end
    endtask

    task automatic test_illegal_select();
        set_in(1'b0, 1'b0, 8'h00, 2'b00);
        in_valid3 = 1'b1; sel3 = 2'd3; in_data3 = 8'hFF; out_ready3 = 3'b000;
        #1;
        checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b want 1", in_ready3); end
        tick();
        in_valid3 = 1'b0;
        #1;
        checks++; if (err3 !== 1'b1 || out_valid3 !== 3'b000) begin
            errors++; $display("FAIL illegal_err: err %b valid %b want 1 000", err3, out_valid3);
        end
        tick();
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %b want 0", err3); end
        in_valid3 = 1'b1; sel3 = 2'd2; in_data3 = 8'h5A;
        #1;
        checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL port2_ready: got %b want 1", in_ready3); end
        tick();
        checks++; if (out_valid3 !== 3'b100 || out_data3[23:16] !== 8'h5A || err3 !== 1'b0) begin
            errors++; $display("FAIL port2_load: valid %b data %h err %b want 100 5a 0", out_valid3, out_data3[23:16], err3);
        end
        checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL port2_stall: got %b want 0", in_ready3); end
        sel3 = 2'd3; in_data3 = 8'hEE;
        #1;
        checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL illegal_while_stall: got %b want 1", in_ready3); end
        tick();
        in_valid3 = 1'b0;
        #1;
        checks++; if (err3 !== 1'b1 || out_valid3 !== 3'b100 || out_data3[23:16] !== 8'h5A) begin
            errors++; $display("FAIL illegal_keep: err %b valid %b data %h want 1 100 5a", err3, out_valid3, out_data3[23:16]);
        end
        out_ready3 = 3'b111;
        tick();
        checks++; if (out_valid3 !== 3'b000 || err3 !== 1'b0) begin
            errors++; $display("FAIL port2_drain: valid %b err %b want 000 0", out_valid3, err3);
        end
    endtask

`ifdef STREAM_DEMUX_CNT_EN
    task automatic test_counters();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 8'h00, 2'b00);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 1'b1, 8'($urandom), 2'b11);
            tick();
        end
        set_in(1'b0, 1'b0, 8'h00, 2'b11);
        tick();
        tick();
        checks++; if (cnt[31:16] !== 16'd5 || cnt[15:0] !== 16'd0) begin
            errors++; $display("FAIL cnt_five: port1 %0d port0 %0d want 5 0", cnt[31:16], cnt[15:0]);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 8'(i + 8'h40), 2'b10);
            tick();
        end
        rst = 1'b1;
        set_in(1'b1, 1'b1, 8'h99, 2'b11);
        tick();
        checks++; if (cnt !== 32'd0 || out_valid !== 2'b00) begin
            errors++; $display("FAIL cnt_reset: cnt %h valid %b want 0 00", cnt, out_valid);
        end
        rst = 1'b0;
        set_in(1'b0, 1'b0, 8'h00, 2'b11);
        tick();
        checks++; if (out_valid !== 2'b00 || cnt !== 32'd0) begin
            errors++; $display("FAIL cnt_after_reset: cnt %h valid %b want 0 00", cnt, out_valid);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 2'($urandom));
            checks++; if (in_ready !== m_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, m_ready());
            end
            for (int k = 0; k < 2; k++) begin
                checks++; if (out_valid[k] !== (mcnt[k] != 0)) begin
                    errors++; $display("FAIL rand_valid%0d[%0d]: got %b want %b", k, c, out_valid[k], mcnt[k] != 0);
                end
                if (mcnt[k] != 0) begin
                    checks++; if (out_data[k*8 +: 8] !== mbuf[k][mhead[k]]) begin
                        errors++; $display("FAIL rand_data%0d[%0d]: got %h want %h", k, c, out_data[k*8 +: 8], mbuf[k][mhead[k]]);
                    end
                end
`ifdef STREAM_DEMUX_CNT_EN
                checks++; if (cnt[k*16 +: 16] !== 16'(mcount[k])) begin
                    errors++; $display("FAIL rand_cnt%0d[%0d]: got %0d want %0d", k, c, cnt[k*16 +: 16], mcount[k]);
                end
`endif
            end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err[%0d]: got %b want 0", c, err); end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mhead[k] = 0; mcnt[k] = 0; mcount[k] = 0;
        end
        rst        = 1'b0;
        in_valid   = 1'b0;
        sel        = 1'b0;
        in_data    = 8'h00;
        out_ready  = 2'b00;
        in_valid3  = 1'b0;
        sel3       = 2'd0;
        in_data3   = 8'h00;
        out_ready3 = 3'b000;
        test_reset();
        test_routing();
        test_stall_isolation();
        test_back_to_back();
        test_illegal_select();
`ifdef STREAM_DEMUX_CNT_EN
        test_counters();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-NUM_OUT demultiplexer for valid/ready streams; the inverse of the 2:1 select mux.
- Routes each accepted input beat to the output port chosen by sel_i.
- One registered holding stage per output, so latency is fixed at 1 cycle.
- A stall on one output must not block traffic to the other outputs.

Parameters:
- NUM_OUT, 2, number of output ports (>=2).
- DATA_W, 8, payload width in bits.
- SEL_W, $clog2(NUM_OUT), select width (derived; not to be overridden).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat accepted when in_valid_i && in_ready_o.
- sel_i  input  SEL_W  destination port; sampled with the beat.
- in_data_i  input  DATA_W  input payload.
- out_valid_o  output  NUM_OUT  per-port valid; bit k is port k.
- out_ready_i  input  NUM_OUT  per-port ready.
- out_data_o  output  NUM_OUT*DATA_W  packed payloads; port k uses bits [k*DATA_W +: DATA_W].
- err_o  output  1  one-cycle pulse on an accepted beat with an illegal select.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - out_valid_o = 0, out_data_o = 0, err_o = 0.
  - All holding registers are emptied; in-flight beats are discarded, not delivered.
  - During reset, in_ready_o = 0.
- Holding register per port k: vld_q[k], dat_q[k].
  - out_valid_o[k] = vld_q[k].
  - out_data_o slice k = dat_q[k], registered; no combinational path from in_data_i.
- Acceptance:
  - in_ready_o = !rst_i && (sel_i >= NUM_OUT || !vld_q[sel_i] || out_ready_i[sel_i]).
  - This is combinational from sel_i and out_ready_i, so the full port supports back-to-back throughput.
- Per port k, per clock edge:
  - drain = vld_q[k] && out_ready_i[k].
  - load = in_valid_i && in_ready_o && sel_i == k.
  - load: vld_q[k] <= 1 and dat_q[k] <= in_data_i. Load wins over drain, so a simultaneous load and drain keeps vld_q[k] = 1 with new data.
  - drain only: vld_q[k] <= 0. dat_q[k] holds its value; out_data_o is only meaningful while valid.
  - Neither: hold.
- Latency: a beat accepted at edge N appears on out_valid_o/out_data_o after edge N.
- Throughput: 1 beat/cycle to any port whose ready is held high.
- Ordering: beats to the same port are delivered in acceptance order. Beats to different ports have no ordering relation.
- Independence: a stalled port (vld_q[k]=1, out_ready_i[k]=0) deasserts in_ready_o only while sel_i == k.
- Illegal select (sel_i >= NUM_OUT, possible only when NUM_OUT is not a power of 2):
  - Beat is accepted (in_ready_o = 1) and dropped.
  - err_o = 1 for the cycle after acceptance; otherwise err_o = 0.
- Output stability: while out_valid_o[k]=1 and out_ready_i[k]=0, out_data_o slice k is held stable.
- Input stability: in_valid_i may deassert without a transfer; no input stability requirement is imposed on the upstream.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined: adds output port cnt_o, NUM_OUT*16 bits, one 16-bit counter per port.
  - Counter k increments on each drain of port k.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst_i.
  - A simultaneous reset and drain yields 0.
- Undefined: cnt_o port and the counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with in_valid_i=1 and sel_i=0 -> in_ready_o=0, out_valid_o=2'b00, err_o=0; after release out_valid_o stays 2'b00 until the first accepted beat.
- Routing: out_ready_i=2'b11; send 8'hA5 with sel=0, then 8'h3C with sel=1 on consecutive cycles -> port 0 shows A5 one cycle after accept; port 1 shows 3C the next cycle; in_ready_o=1 throughout.
- Stall isolation: out_ready_i=2'b10; send 8'h11 with sel=0, then 8'h22 with sel=0, then 8'h33 with sel=1 -> 11 held on port 0 and in_ready_o=0 while sel=0; switching to sel=1 gets 33 accepted and delivered; raising out_ready_i[0] drains 11, then 22 is accepted.
- Back-to-back with simultaneous load and drain: out_ready_i[0]=1; stream 8'h01..8'h10 with sel=0 -> 16 beats over 16 consecutive cycles in order, out_valid_o[0] continuous.
- Illegal select: NUM_OUT=3, SEL_W=2; send sel=3 with 8'hFF -> in_ready_o=1, err_o pulses 1 cycle, out_valid_o unchanged (3'b000).
- Counters (STREAM_DEMUX_CNT_EN defined): 5 beats drained on port 1 -> cnt_o slice 1 = 5, slice 0 = 0; assert rst_i mid-stream -> all counters 0 and all holding registers empty.
